// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : audio_pkg
// Brief   : Shared sample/frame constants, mix-mode enum and the
//           unsigned-to-signed helper for the I2S transmit path.
// Revision: 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 64;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        MIX_NONE = 2'd0,
        MIX_25   = 2'd1,
        MIX_50   = 2'd2,
        MIX_MONO = 2'd3
    } mix_mode_t;

    // Offset-binary to two's complement is a flip of the MSB.
    function automatic logic [SAMPLE_W-1:0] to_signed_fmt(
        input logic [SAMPLE_W-1:0] x,
        input logic                is_signed
    );
        return {x[SAMPLE_W-1] ^ ~is_signed, x[SAMPLE_W-2:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_i2s_mix.sv
`default_nettype none
// ============================================================================
// Module  : audio_i2s_mix
// Brief   : Combinational sign conversion and stereo cross-mix feeding the
//           frame load. Mix stage present only with AUDIO_I2S_MIX_EN defined.
// Revision: 1.0 - initial release
// ============================================================================
module audio_i2s_mix
    import audio_pkg::*;
(
    input  logic [SAMPLE_W-1:0] l_in,
    input  logic [SAMPLE_W-1:0] r_in,
    input  logic                is_signed,
    input  mix_mode_t           mix,
    output logic [SAMPLE_W-1:0] l_out,
    output logic [SAMPLE_W-1:0] r_out
);

    logic [SAMPLE_W-1:0] w_l;
    logic [SAMPLE_W-1:0] w_r;

    assign w_l = to_signed_fmt(l_in, is_signed);
    assign w_r = to_signed_fmt(r_in, is_signed);

`ifdef AUDIO_I2S_MIX_EN
    localparam int ACC_W = SAMPLE_W + 3;

    logic signed [ACC_W-1:0] w_ls;
    logic signed [ACC_W-1:0] w_rs;
    logic signed [ACC_W-1:0] w_lm;
    logic signed [ACC_W-1:0] w_rm;

    assign w_ls = {{3{w_l[SAMPLE_W-1]}}, w_l};
    assign w_rs = {{3{w_r[SAMPLE_W-1]}}, w_r};

    // 19 bits hold 8 * -32768 exactly, so no intermediate can overflow.
    always_comb begin
        w_lm = w_ls;
        w_rm = w_rs;
        case (mix)
            MIX_25: begin
                w_lm = ((w_ls <<< 1) + w_ls + w_rs) >>> 2;
                w_rm = ((w_rs <<< 1) + w_rs + w_ls) >>> 2;
            end
            MIX_50: begin
                w_lm = ((w_ls <<< 2) + w_ls + (w_rs <<< 1) + w_rs) >>> 3;
                w_rm = ((w_rs <<< 2) + w_rs + (w_ls <<< 1) + w_ls) >>> 3;
            end
            MIX_MONO: begin
                w_lm = (w_ls + w_rs) >>> 1;
                w_rm = (w_ls + w_rs) >>> 1;
            end
            default: ;
        endcase
    end

    assign l_out = w_lm[SAMPLE_W-1:0];
    assign r_out = w_rm[SAMPLE_W-1:0];
`else
    logic w_unused_mix;
    assign w_unused_mix = ^mix;

    assign l_out = w_l;
    assign r_out = w_r;
`endif

endmodule
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : audio_i2s_tx
// Brief   : I2S transmitter, 64-BCK frame, 16-bit left/right with one-BCK
//           delay, single-entry holding register. Optional mix: AUDIO_I2S_MIX_EN.
// Revision: 1.0 - initial release
// ============================================================================
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int SCLK_DIV = 8
) (
    input  logic                CLK_50M,
    input  logic                RESET_N,
    input  logic [SAMPLE_W-1:0] audio_l,
    input  logic [SAMPLE_W-1:0] audio_r,
    input  logic                audio_s,
    input  logic [1:0]          audio_mix,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                I2S_BCK,
    output logic                I2S_LRCK,
    output logic                I2S_DATA,
    output logic                underrun
);

    localparam logic [7:0]           DIV_LAST = 8'(SCLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] L_FIRST  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] L_LAST   = BIT_CNT_W'(SAMPLE_W);
    localparam logic [BIT_CNT_W-1:0] R_FIRST  = BIT_CNT_W'(FRAME_BITS / 2 + 1);
    localparam logic [BIT_CNT_W-1:0] R_LAST   = BIT_CNT_W'(FRAME_BITS / 2 + SAMPLE_W);

    logic [7:0]           div_q, div_d;
    logic                 bck_q, bck_d;
    logic [BIT_CNT_W-1:0] b_q, b_d;
    logic                 lrck_q, lrck_d;
    logic                 data_q, data_d;
    logic                 underrun_q, underrun_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [SAMPLE_W-1:0]  hold_l_q, hold_l_d;
    logic [SAMPLE_W-1:0]  hold_r_q, hold_r_d;
    logic                 hold_s_q, hold_s_d;
    mix_mode_t            hold_mix_q, hold_mix_d;
    logic [SAMPLE_W-1:0]  sh_l_q, sh_l_d;
    logic [SAMPLE_W-1:0]  sh_r_q, sh_r_d;

    logic                 w_tick;
    logic                 w_fall;
    logic                 w_load;
    logic                 w_accept;
    logic [BIT_CNT_W-1:0] w_b_next;
    logic [SAMPLE_W-1:0]  w_mix_l;
    logic [SAMPLE_W-1:0]  w_mix_r;

    audio_i2s_mix u_mix (
        .l_in      (hold_l_q),
        .r_in      (hold_r_q),
        .is_signed (hold_s_q),
        .mix       (hold_mix_q),
        .l_out     (w_mix_l),
        .r_out     (w_mix_r)
    );

    always_comb begin
        w_tick   = (div_q == DIV_LAST);
        w_fall   = w_tick & bck_q;
        w_b_next = b_q + BIT_CNT_W'(1);
        w_load   = w_fall & (w_b_next == '0);
        w_accept = sample_valid & ~hold_valid_q;

        div_d  = w_tick ? 8'd0 : div_q + 8'd1;
        bck_d  = bck_q ^ w_tick;
        b_d    = w_fall ? w_b_next : b_q;
        lrck_d = w_fall ? w_b_next[BIT_CNT_W-1] : lrck_q;

        data_d = data_q;
        sh_l_d = sh_l_q;
        sh_r_d = sh_r_q;
        if (w_load) begin
            data_d = 1'b0;
            sh_l_d = hold_valid_q ? w_mix_l : '0;
            sh_r_d = hold_valid_q ? w_mix_r : '0;
        end else if (w_fall) begin
            data_d = 1'b0;
            if ((w_b_next >= L_FIRST) && (w_b_next <= L_LAST)) begin
                data_d = sh_l_q[SAMPLE_W-1];
                sh_l_d = sh_l_q << 1;
            end else if ((w_b_next >= R_FIRST) && (w_b_next <= R_LAST)) begin
                data_d = sh_r_q[SAMPLE_W-1];
                sh_r_d = sh_r_q << 1;
            end
        end

        // A load with an empty holding register still keeps a same-cycle accept.
        hold_valid_d = (hold_valid_q & ~w_load) | w_accept;
        hold_l_d     = w_accept ? audio_l : hold_l_q;
        hold_r_d     = w_accept ? audio_r : hold_r_q;
        hold_s_d     = w_accept ? audio_s : hold_s_q;
        hold_mix_d   = w_accept ? mix_mode_t'(audio_mix) : hold_mix_q;
        underrun_d   = w_load & ~hold_valid_q;
    end

    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q        <= 8'd0;
            bck_q        <= 1'b0;
            b_q          <= '1;
            lrck_q       <= 1'b0;
            data_q       <= 1'b0;
            underrun_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            hold_s_q     <= 1'b0;
            hold_mix_q   <= MIX_NONE;
            sh_l_q       <= '0;
            sh_r_q       <= '0;
        end else begin
            div_q        <= div_d;
            bck_q        <= bck_d;
            b_q          <= b_d;
            lrck_q       <= lrck_d;
            data_q       <= data_d;
            underrun_q   <= underrun_d;
            hold_valid_q <= hold_valid_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            hold_s_q     <= hold_s_d;
            hold_mix_q   <= hold_mix_d;
            sh_l_q       <= sh_l_d;
            sh_r_q       <= sh_r_d;
        end
    end

    assign sample_ready = ~hold_valid_q;
    assign I2S_BCK      = bck_q;
    assign I2S_LRCK     = lrck_q;
    assign I2S_DATA     = data_q;
    assign underrun     = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_audio_i2s_tx
// Brief   : Directed self-checking bench for audio_i2s_tx (SCLK_DIV = 8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

    localparam logic [63:0] DATA_MASK = 64'h0001_FFFE_0001_FFFE;

    logic        CLK_50M = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] audio_l = '0;
    logic [15:0] audio_r = '0;
    logic        audio_s = 1'b0;
    logic [1:0]  audio_mix = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        I2S_BCK;
    logic        I2S_LRCK;
    logic        I2S_DATA;
    logic        underrun;

    int unsigned k;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] feed_l;
    logic [15:0] feed_r;

    audio_i2s_tx #(.SCLK_DIV(8)) dut (
        .CLK_50M      (CLK_50M),
        .RESET_N      (RESET_N),
        .audio_l      (audio_l),
        .audio_r      (audio_r),
        .audio_s      (audio_s),
        .audio_mix    (audio_mix),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .I2S_BCK      (I2S_BCK),
        .I2S_LRCK     (I2S_LRCK),
        .I2S_DATA     (I2S_DATA),
        .underrun     (underrun)
    );

    always #5 CLK_50M = ~CLK_50M;

    // Clock edges since reset release; frame loads land on k = 16 + 1024*m.
    always @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) k <= 0;
        else          k <= k + 1;
    end

    task automatic step();
        @(negedge CLK_50M);
    endtask

    function automatic logic [15:0] word_at(input logic [63:0] d, input int first);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = d[first+i];
        return w;
    endfunction

    // Records one whole frame starting at the next frame load; tim counts
    // BCK/LRCK pattern errors and data changes inside a bit period.
    task automatic capture(input bit feed, output logic [63:0] dbits, output int tim,
                           output int urun, output int hs, output int rdy_hi,
                           output logic [15:0] acc_l, output logic [15:0] acc_r);
        int guard;
        bit pend;
        int b;
        guard = 0; pend = 0;
        dbits = '0; tim = 0; urun = 0; hs = 0; rdy_hi = 0; acc_l = '0; acc_r = '0;
        while ((k % 1024) != 16) begin
            step();
            guard++;
            if (guard > 2100) begin
                checks++; errors++;
                $display("FAIL frame_align: no frame boundary within %0d cycles", guard);
                return;
            end
        end
        for (int t = 0; t < 1024; t++) begin
            b = t / 16;
            if (pend) begin
                hs++;
                acc_l = feed_l; acc_r = feed_r;
                feed_l = feed_l + 16'h1357;
                feed_r = feed_r - 16'h0421;
                pend = 0;
            end
            if (feed) begin
                sample_valid = 1'b1; audio_l = feed_l; audio_r = feed_r;
                audio_s = 1'b1; audio_mix = 2'd0;
            end
            if (I2S_BCK !== ((t % 16) >= 8)) tim++;
            if (I2S_LRCK !== (b >= 32)) tim++;
            if ((t % 16) == 8) dbits[b] = I2S_DATA;
            if ((t % 16) == 15 && I2S_DATA !== dbits[b]) tim++;
            if (underrun === 1'b1) urun++;
            if (sample_ready === 1'b1) rdy_hi++;
            if (sample_valid && sample_ready) pend = 1;
            step();
        end
        if (feed) sample_valid = 1'b0;
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r,
                         input logic s, input logic [1:0] mix);
        int guard;
        guard = 0;
        while (sample_ready !== 1'b1 && guard < 2100) begin
            step();
            guard++;
        end
        audio_l = l; audio_r = r; audio_s = s; audio_mix = mix;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (4) step();
        checks++;
        if ({I2S_BCK, I2S_LRCK, I2S_DATA, underrun, sample_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 00001",
                     {I2S_BCK, I2S_LRCK, I2S_DATA, underrun, sample_ready});
        end
        RESET_N = 1'b1;
        while (k < 15) step();
        checks++;
        if ({I2S_BCK, underrun} !== 2'b10) begin
            errors++;
            $display("FAIL pre_first_fall: bck/underrun got %b, expected 10", {I2S_BCK, underrun});
        end
        step();
        checks++;
        if ({I2S_BCK, underrun} !== 2'b01) begin
            errors++;
            $display("FAIL first_frame_load: bck/underrun got %b, expected 01", {I2S_BCK, underrun});
        end
    endtask

    task automatic test_idle();
        logic [63:0] d; int tim, urun, hs, rdy; logic [15:0] al, ar;
        for (int f = 0; f < 2; f++) begin
            capture(1'b0, d, tim, urun, hs, rdy, al, ar);
            checks++;
            if (tim !== 0) begin
                errors++; $display("FAIL idle_timing: %0d pattern errors, expected 0", tim);
            end
            checks++;
            if (d !== 64'd0) begin
                errors++; $display("FAIL idle_data: got %h, expected 0", d);
            end
            checks++;
            if (urun !== 1) begin
                errors++; $display("FAIL idle_underrun: got %0d pulses, expected 1", urun);
            end
        end
    endtask

    task automatic test_sample(input string name, input logic [15:0] l, input logic [15:0] r,
                               input logic s, input logic [1:0] mix,
                               input logic [15:0] exp_l, input logic [15:0] exp_r);
        logic [63:0] d; int tim, urun, hs, rdy; logic [15:0] al, ar;
        offer(l, r, s, mix);
        checks++;
        if (sample_ready !== 1'b0) begin
            errors++; $display("FAIL %s ready_after_accept: got %b, expected 0", name, sample_ready);
        end
        capture(1'b0, d, tim, urun, hs, rdy, al, ar);
        checks++;
        if (word_at(d, 1) !== exp_l) begin
            errors++; $display("FAIL %s left: got %h, expected %h", name, word_at(d, 1), exp_l);
        end
        checks++;
        if (word_at(d, 33) !== exp_r) begin
            errors++; $display("FAIL %s right: got %h, expected %h", name, word_at(d, 33), exp_r);
        end
        checks++;
        if ((d & ~DATA_MASK) !== 64'd0 || tim !== 0 || urun !== 0) begin
            errors++;
            $display("FAIL %s frame: stray bits %h timing errs %0d underruns %0d, expected 0/0/0",
                     name, d & ~DATA_MASK, tim, urun);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] d; int tim, urun, hs, rdy; logic [15:0] al, ar;
        RESET_N = 1'b0;
        repeat (3) step();
        RESET_N = 1'b1;
        while (k < 15) step();
        audio_l = 16'h1234; audio_r = 16'h5678; audio_s = 1'b1; audio_mix = 2'd0;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        checks++;
        if ({underrun, sample_ready} !== 2'b10) begin
            errors++; $display("FAIL simul_load: underrun/ready got %b, expected 10", {underrun, sample_ready});
        end
        capture(1'b0, d, tim, urun, hs, rdy, al, ar);
        checks++;
        if (d !== 64'd0 || urun !== 1 || tim !== 0) begin
            errors++; $display("FAIL simul_frame0: data %h underruns %0d timing %0d, expected 0/1/0", d, urun, tim);
        end
        capture(1'b0, d, tim, urun, hs, rdy, al, ar);
        checks++;
        if ({word_at(d, 1), word_at(d, 33)} !== 32'h1234_5678 || urun !== 0) begin
            errors++;
            $display("FAIL simul_frame1: got %h/%h underruns %0d, expected 1234/5678/0",
                     word_at(d, 1), word_at(d, 33), urun);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; int tim, urun, hs, rdy; logic [15:0] al, ar, pl, pr;
        feed_l = 16'h0101; feed_r = 16'hF0F0;
        capture(1'b1, d, tim, urun, hs, rdy, pl, pr);
        checks++;
        if (hs !== 1) begin
            errors++; $display("FAIL b2b_first_handshake: got %0d, expected 1", hs);
        end
        for (int w = 1; w < 4; w++) begin
            capture(1'b1, d, tim, urun, hs, rdy, al, ar);
            checks++;
            if (hs !== 1 || rdy !== 1 || urun !== 0) begin
                errors++;
                $display("FAIL b2b_flow[%0d]: handshakes %0d ready cycles %0d underruns %0d, expected 1/1/0",
                         w, hs, rdy, urun);
            end
            checks++;
            if ({word_at(d, 1), word_at(d, 33)} !== {pl, pr}) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h/%h, expected %h/%h",
                         w, word_at(d, 1), word_at(d, 33), pl, pr);
            end
            pl = al; pr = ar;
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] d; int tim, urun, hs, rdy; logic [15:0] al, ar;
        int guard;
        offer(16'hFFFF, 16'hFFFF, 1'b1, 2'd0);
        guard = 0;
        while ((k % 1024) != 16 && guard < 2100) begin
            step(); guard++;
        end
        repeat (10 * 16 + 11) step();
        checks++;
        if ({I2S_BCK, I2S_DATA} !== 2'b11) begin
            errors++; $display("FAIL pre_reset_b10: bck/data got %b, expected 11", {I2S_BCK, I2S_DATA});
        end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if ({I2S_BCK, I2S_LRCK, I2S_DATA, underrun, sample_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL midframe_reset: got %b, expected 00001",
                     {I2S_BCK, I2S_LRCK, I2S_DATA, underrun, sample_ready});
        end
        repeat (3) step();
        RESET_N = 1'b1;
        capture(1'b0, d, tim, urun, hs, rdy, al, ar);
        checks++;
        if (d !== 64'd0 || urun !== 1 || tim !== 0) begin
            errors++;
            $display("FAIL post_reset_frame: data %h underruns %0d timing %0d, expected 0/1/0", d, urun, tim);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sample("format", 16'hA5F0, 16'h0F0F, 1'b1, 2'd0, 16'hA5F0, 16'h0F0F);
        test_sample("unsigned_mid", 16'h8000, 16'h8000, 1'b0, 2'd0, 16'h0000, 16'h0000);
        test_sample("unsigned_edge", 16'h0001, 16'hFFFF, 1'b0, 2'd0, 16'h8001, 16'h7FFF);
`ifdef AUDIO_I2S_MIX_EN
        test_sample("mix25", 16'h1000, 16'h3000, 1'b1, 2'd1, 16'h1800, 16'h2800);
        test_sample("mix50", 16'h1000, 16'h3000, 1'b1, 2'd2, 16'h1C00, 16'h2400);
        test_sample("mono", 16'h1000, 16'h3000, 1'b1, 2'd3, 16'h2000, 16'h2000);
        test_sample("mono_floor", 16'hFFFF, 16'h0000, 1'b1, 2'd3, 16'hFFFF, 16'hFFFF);
        test_sample("mono_unsigned", 16'h8000, 16'hC000, 1'b0, 2'd3, 16'h2000, 16'h2000);
`else
        test_sample("mix_disabled", 16'h1000, 16'h3000, 1'b1, 2'd3, 16'h1000, 16'h3000);
        test_sample("mix_disabled_us", 16'h8000, 16'hC000, 1'b0, 2'd1, 16'h0000, 16'h4000);
`endif
        test_simultaneous();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
